dm_access_unit: RTL and testbench

- Sequential memory-access stage directly downstream of the byte-enable decoder in the MEM stage.
- Takes the MEM-stage access (address, word mode, byte enables, raw store data) and runs one transaction on the req/ack data bus.
- Stalls the pipeline until the bus completes.
- Returns load data extracted and sign/zero-extended per word mode, for the WB stage.

---
 rtl/dm_access_unit_pkg.sv | 29 ++
 rtl/dm_load_ext.sv | 27 ++
 rtl/dm_access_unit.sv | 155 +++++++++++++++
 tb/tb_dm_access_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_unit_pkg.sv
// Shared definitions for the data-memory access stage: word modes, FSM states, store lane placement.
// Latency: n/a (types, constants and a combinational helper). Backpressure: n/a.
package dm_access_unit_pkg;

    localparam logic [2:0] wm_wd = 3'd0;
    localparam logic [2:0] wm_hu = 3'd1;
    localparam logic [2:0] wm_hs = 3'd2;
    localparam logic [2:0] wm_bu = 3'd3;
    localparam logic [2:0] wm_bs = 3'd4;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_req  = 2'd1,
        st_done = 2'd2
    } dm_state_t;

    // Replicate sub-word store data across every lane so the byte enables pick the right one.
    function automatic logic [31:0] place_wdata(input logic [2:0] wm, input logic [31:0] wd);
        logic [31:0] r;
        r = wd;
        case (wm)
            wm_bu, wm_bs: r = {4{wd[7:0]}};
            wm_hu, wm_hs: r = {2{wd[15:0]}};
            default:      r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select plus sign/zero extension by word mode.
// Latency: purely combinational. Backpressure: none.
module dm_load_ext
    import dm_access_unit_pkg::*;
(
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  wordmode,
    output logic [31:0] rdata
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = bus_rdata[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (wordmode)
            wm_hu:   rdata = {16'h0000, h};
            wm_hs:   rdata = {{16{h[15]}}, h};
            wm_bu:   rdata = {24'h000000, b};
            wm_bs:   rdata = {{24{b[7]}}, b};
            default: rdata = bus_rdata;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage bus access: one req/ack transaction per load/store; optional misalign trap via DM_MISALIGN_CHK_EN.
// Latency: 2 stall cycles minimum (ack in first REQ cycle), 1 for a trapped misaligned access.
// Backpressure: stall holds upstream until DONE; bus_req held until bus_ack or TIMEOUT abort.
module dm_access_unit
    import dm_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_wordmode,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_err,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] cnt_last = CNT_W'(TIMEOUT - 1);

    dm_state_t        state, state_nxt;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [2:0]       wm_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] cnt;
    logic             err_pend;
    logic             mis_pend;
    logic [31:0]      rdata_q;
    logic [31:0]      ext;
    logic             mis_det;
    logic             timeout_hit;

`ifdef DM_MISALIGN_CHK_EN
    assign mis_det = ((req_wordmode == wm_wd) && (req_addr[1:0] != 2'b00)) ||
                     (((req_wordmode == wm_hu) || (req_wordmode == wm_hs)) && req_addr[0]);
`else
    assign mis_det = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (cnt == cnt_last);

    dm_load_ext u_load_ext (
        .bus_rdata (bus_rdata),
        .addr_lo   (addr_q[1:0]),
        .wordmode  (wm_q),
        .rdata     (ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        bus_req     = 1'b0;
        rdata_valid = 1'b0;
        bus_err     = 1'b0;
        misalign    = 1'b0;
        case (state)
            st_idle: begin
                // Gated so stall reads 0 for the whole reset window, not just after release.
                stall = req_valid & ~reset;
                if (req_valid) begin
                    state_nxt = mis_det ? st_done : st_req;
                end
            end
            st_req: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (bus_ack || timeout_hit) begin
                    state_nxt = st_done;
                end
            end
            st_done: begin
                rdata_valid = 1'b1;
                bus_err     = err_pend;
                misalign    = mis_pend;
                state_nxt   = st_idle;
            end
            default: state_nxt = st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wm_q     <= 3'd0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            cnt      <= '0;
            err_pend <= 1'b0;
            mis_pend <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            case (state)
                st_idle: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        addr_q   <= req_addr;
                        wm_q     <= req_wordmode;
                        be_q     <= req_be;
                        wdata_q  <= req_wdata;
                        cnt      <= '0;
                        err_pend <= 1'b0;
                        mis_pend <= mis_det;
                        if (mis_det) begin
                            rdata_q <= 32'h0;
                        end
                    end
                end
                st_req: begin
                    cnt <= cnt + CNT_W'(1);
                    // Ack wins over a coincident timeout.
                    if (bus_ack) begin
                        if (!we_q) begin
                            rdata_q <= ext;
                        end
                    end else if (timeout_hit) begin
                        err_pend <= 1'b1;
                        rdata_q  <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_be    = be_q;
    assign bus_wdata = place_wdata(wm_q, wdata_q);

endmodule

// File: tb/tb_dm_access_unit.sv
// Randomized scoreboard bench for dm_access_unit with a bus responder and a completion monitor.
module tb_dm_access_unit;
    import dm_access_unit_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 255;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_wordmode;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_err;
    logic        misalign;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    int          ack_delay;
    logic [31:0] resp_data;
    logic [31:0] model_rdata;
    int          n_cmp;
    int          n_err;

    dm_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wordmode (req_wordmode),
        .req_be       (req_be),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .bus_err      (bus_err),
        .misalign     (misalign),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: shift the chosen lane down, mask, then extend arithmetically.
    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] a,
                                               input logic [2:0] wm);
        logic [31:0] v;
        case (wm)
            3'd3, 3'd4: begin
                v = (d >> (8 * int'(a))) & 32'hFF;
                if (wm == 3'd4 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd2: begin
                v = (d >> (16 * int'(a[1]))) & 32'hFFFF;
                if (wm == 3'd2 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] wm);
        if (wm == 3'd3 || wm == 3'd4) return (wd & 32'hFF) * 32'h01010101;
        if (wm == 3'd1 || wm == 3'd2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] a, input logic [2:0] wm);
        if (wm == 3'd3 || wm == 3'd4) return 4'(1 << int'(a));
        if (wm == 3'd1 || wm == 3'd2) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic bit model_mis(input logic [1:0] a, input logic [2:0] wm);
`ifdef DM_MISALIGN_CHK_EN
        if (wm == 3'd0) return a != 2'b00;
        if (wm == 3'd1 || wm == 3'd2) return a[0];
`endif
        return 1'b0;
    endfunction

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [2:0] wm,
                          input logic [31:0] wdata, input int delay, input logic [31:0] resp);
        exp_t e;
        bus_t b;
        bit   mis;
        bit   err;
        int   exp_stall;
        int   sc;
        bit   done;
        mis = model_mis(addr[1:0], wm);
        err = !mis && (TIMEOUT != 0) && (delay >= TIMEOUT);
        exp_stall = mis ? 1 : (err ? 1 + TIMEOUT : 2 + delay);
        if (mis || err)  e.rdata = 32'h0;
        else if (we)     e.rdata = model_rdata;
        else             e.rdata = model_load(resp, addr[1:0], wm);
        e.err = err;
        e.mis = mis;
        model_rdata = e.rdata;
        exp_q.push_back(e);
        if (!mis) begin
            b.addr  = addr & 32'hFFFF_FFFC;
            b.be    = model_be(addr[1:0], wm);
            b.we    = we;
            b.wdata = model_wdata(wdata, wm);
            bus_q.push_back(b);
        end
        @(posedge clk);
        #1;
        ack_delay    = delay;
        resp_data    = resp;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wordmode = wm;
        req_be       = model_be(addr[1:0], wm);
        req_wdata    = wdata;
        sc   = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (stall) sc++;
            else done = 1'b1;
        end
        check("stall_cycles", 32'(sc), 32'(exp_stall));
    endtask

    // Bus responder: acks after ack_delay REQ cycles, checks bus fields every REQ cycle,
    // and throws stray acks while no request is pending.
    initial begin
        bus_t cur;
        bit   active;
        int   wait_cnt;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        active    = 1'b0;
        wait_cnt  = 0;
        cur       = '{32'h0, 4'h0, 1'b0, 32'h0};
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_req) begin
                if (!active) begin
                    active   = 1'b1;
                    wait_cnt = 0;
                    if (bus_q.size() == 0) begin
                        check("unexpected_bus_req", 32'(bus_req), 32'h0);
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end
                check("bus_addr", bus_addr, cur.addr);
                check("bus_be", 32'(bus_be), 32'(cur.be));
                check("bus_we", 32'(bus_we), 32'(cur.we));
                check("bus_wdata", bus_wdata, cur.wdata);
                if (wait_cnt == ack_delay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = resp_data;
                end
                wait_cnt++;
            end else begin
                active = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    bus_ack   = 1'b1;
                    bus_rdata = $urandom;
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rdata_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rdata_valid", 32'(rdata_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", rdata, e.rdata);
                    check("bus_err", 32'(bus_err), 32'(e.err));
                    check("misalign", 32'(misalign), 32'(e.mis));
                    check("bus_req_in_done", 32'(bus_req), 32'h0);
                end
            end else begin
                check("stray_bus_err", 32'(bus_err), 32'h0);
                check("stray_misalign", 32'(misalign), 32'h0);
            end
        end
    end

    initial begin
        logic        we;
        logic [2:0]  wm;
        int          r;
        int          dly;
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_wordmode = 3'd0;
        req_be       = 4'h0;
        req_wdata    = 32'h0;
        ack_delay    = 0;
        resp_data    = 32'h0;
        model_rdata  = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        reset = 1'b0;

        do_txn(1'b0, 32'h100, wm_wd, 32'h0, 0, 32'hDEADBEEF);
        do_txn(1'b0, 32'h103, wm_bs, 32'h0, 1, 32'h80112233);
        do_txn(1'b0, 32'h103, wm_bu, 32'h0, 0, 32'h80112233);
        do_txn(1'b1, 32'h202, wm_hs, 32'h1234ABCD, 2, 32'hCAFEF00D);
        do_txn(1'b0, 32'h104, wm_wd, 32'h0, NEVER, 32'h0);
        do_txn(1'b0, 32'h10A, wm_hs, 32'h0, TIMEOUT - 1, 32'h9ABC5555);
        do_txn(1'b0, 32'h108, wm_wd, 32'h0, 1, 32'h5555AAAA);

        // Reset while the bus request is outstanding.
        @(posedge clk);
        #1;
        ack_delay    = NEVER;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h300;
        req_wordmode = wm_wd;
        req_be       = 4'hF;
        req_wdata    = 32'h0;
        bus_q.push_back('{32'h300, 4'hF, 1'b0, 32'h0});
        repeat (3) @(negedge clk);
        check("pre_rst_bus_req", 32'(bus_req), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_stall", 32'(stall), 32'h0);
        check("mid_rst_bus_req", 32'(bus_req), 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_rdata_valid", 32'(rdata_valid), 32'h0);
        model_rdata = 32'h0;
        req_valid   = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;

        do_txn(1'b0, 32'h400, wm_hu, 32'h0, 0, 32'h8001F00F);
        do_txn(1'b0, 32'h101, wm_wd, 32'h0, 0, 32'h11223344);
        do_txn(1'b1, 32'h502, wm_bu, 32'h000000A5, 1, 32'h0BADF00D);

        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            wm = 3'($urandom_range(0, 4));
            r  = $urandom_range(0, 19);
            dly = (r == 0) ? NEVER : r % 5;
            do_txn(we, $urandom, wm, $urandom, dly, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end

        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("bus_q_drained", 32'(bus_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
